// File: rtl/dcpu16_pkg.sv
// dcpu16_pkg: shared types and constants for the DCPU-16 core.
// Holds the fetch-unit state encoding, the machine word width and the
// default program counter value after reset.
package dcpu16_pkg;

    localparam int unsigned WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t RESET_PC_DEF = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

endpackage : dcpu16_pkg

// File: rtl/dcpu16_fetch_pf.sv
// dcpu16_fetch_pf: one-word prefetch buffer for dcpu16_fetch.
// Tracks a speculative read of pc+1. The read is started with `start`, and
// it lands in the buffer unless it was killed by a redirect. In that case
// it still completes on the bus and is then dropped. `hit` also covers the
// word that is being acknowledged this cycle, so it can be forwarded at once.
// Only instantiated when DCPU16_FETCH_PREFETCH_EN is defined.
module dcpu16_fetch_pf
    import dcpu16_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              start,
    input  logic              kill,
    input  logic [WORD_W-1:0] start_adr,
    input  logic              iwb_ack,
    input  logic [WORD_W-1:0] iwb_dat,
    output logic              hit,
    output logic              busy,
    output logic [WORD_W-1:0] fwd_dat,
    output logic [WORD_W-1:0] fwd_adr
);

    logic  valid;
    logic  drop;
    word_t buf_dat;
    word_t buf_adr;

    // Buffer state: launch, capture or drop the speculative word.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid   <= 1'b0;
            busy    <= 1'b0;
            drop    <= 1'b0;
            buf_dat <= '0;
            buf_adr <= '0;
        end else if (clr) begin
            valid <= 1'b0;
            busy  <= 1'b0;
            drop  <= 1'b0;
        end else if (start) begin
            valid   <= 1'b0;
            busy    <= 1'b1;
            drop    <= 1'b0;
            buf_adr <= start_adr;
        end else begin
            if (busy && iwb_ack) begin
                busy <= 1'b0;
                drop <= 1'b0;
                if (!drop && !kill) begin
                    valid   <= 1'b1;
                    buf_dat <= iwb_dat;
                end
            end else if (kill) begin
                drop <= busy;
            end
            if (kill) valid <= 1'b0;
        end
    end

    assign hit     = !drop && (valid || (busy && iwb_ack));
    assign fwd_dat = valid ? buf_dat : iwb_dat;
    assign fwd_adr = buf_adr;

endmodule : dcpu16_fetch_pf

// File: rtl/dcpu16_fetch.sv
// dcpu16_fetch: DCPU-16 instruction fetch unit.
// Owns the program counter and reads one word at a time over a strobe/ack
// bus. Each word goes to the control unit over the fs_ena/fs_ack toggle
// pair, and the pipeline stalls while the two differ. A redirect during a
// read lets that read finish, drops its data and relaunches at the target,
// so the stall lasts until the correct word arrives.
// Optional macro DCPU16_FETCH_PREFETCH_EN adds a one-word prefetch buffer
// (dcpu16_fetch_pf) so that straight-line code needs no toggle per word.
module dcpu16_fetch
    import dcpu16_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              pc_ld,
    input  logic [WORD_W-1:0] pc_dti,
    output logic [WORD_W-1:0] fs_dti,
    output logic [WORD_W-1:0] fs_adr,
    output logic              fs_ena,
    output logic              fs_ack,
    output logic [WORD_W-1:0] iwb_adr,
    output logic              iwb_stb,
    input  logic [WORD_W-1:0] iwb_dat,
    input  logic              iwb_ack
);

    fetch_state_e state, state_nxt;
    word_t        pc, pc_nxt;
    word_t        tgt, tgt_nxt;
    logic         pend, pend_nxt;
    word_t        fs_dti_nxt, fs_adr_nxt, iwb_adr_nxt;
    logic         fs_ena_nxt, fs_ack_nxt, iwb_stb_nxt;
    word_t        launch_adr;
    word_t        target;
    logic         redir;

    // A redirect presented this cycle beats one latched earlier.
    assign target = pc_ld ? pc_dti : tgt;
    assign redir  = pc_ld || pend;

`ifdef DCPU16_FETCH_PREFETCH_EN
    logic  pf_clr, pf_start, pf_kill, pf_hit, pf_busy;
    word_t pf_dat, pf_adr;

    dcpu16_fetch_pf u_pf (
        .clk       (clk),
        .rst       (rst),
        .clr       (pf_clr),
        .start     (pf_start),
        .kill      (pf_kill),
        .start_adr (iwb_adr_nxt),
        .iwb_ack   (iwb_ack),
        .iwb_dat   (iwb_dat),
        .hit       (pf_hit),
        .busy      (pf_busy),
        .fwd_dat   (pf_dat),
        .fwd_adr   (pf_adr)
    );
`endif

    // Next-state and next-output logic for the fetch FSM.
    // NOTE: every signal gets its hold value first, so no path infers a latch.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        tgt_nxt     = tgt;
        pend_nxt    = pend;
        fs_dti_nxt  = fs_dti;
        fs_adr_nxt  = fs_adr;
        fs_ena_nxt  = fs_ena;
        fs_ack_nxt  = fs_ack;
        iwb_adr_nxt = iwb_adr;
        iwb_stb_nxt = iwb_stb;
        launch_adr  = pc;
`ifdef DCPU16_FETCH_PREFETCH_EN
        pf_clr   = 1'b0;
        pf_start = 1'b0;
        pf_kill  = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                launch_adr  = pc_ld ? pc_dti : pc;
                pc_nxt      = launch_adr;
                iwb_adr_nxt = launch_adr;
                iwb_stb_nxt = 1'b1;
                fs_ena_nxt  = ~fs_ena;
                state_nxt   = REQ;
            end
            REQ: begin
                if (pc_ld) begin
                    pend_nxt = 1'b1;
                    tgt_nxt  = pc_dti;
                end
                if (iwb_ack) begin
                    if (redir) begin
                        // Stale word: drop it and reissue at the target, stall continues.
                        pc_nxt      = target;
                        iwb_adr_nxt = target;
                        pend_nxt    = 1'b0;
                    end else begin
                        fs_dti_nxt  = iwb_dat;
                        fs_adr_nxt  = iwb_adr;
                        fs_ack_nxt  = ~fs_ack;
                        iwb_stb_nxt = 1'b0;
                        state_nxt   = HOLD;
`ifdef DCPU16_FETCH_PREFETCH_EN
                        iwb_stb_nxt = 1'b1;
                        iwb_adr_nxt = iwb_adr + word_t'(1);
                        pf_start    = 1'b1;
`endif
                    end
                end
            end
            HOLD: begin
`ifdef DCPU16_FETCH_PREFETCH_EN
                if (ena) begin
                    if (!redir && pf_hit) begin
                        fs_dti_nxt  = pf_dat;
                        fs_adr_nxt  = pf_adr;
                        pc_nxt      = pf_adr;
                        iwb_adr_nxt = pf_adr + word_t'(1);
                        iwb_stb_nxt = 1'b1;
                        pf_start    = 1'b1;
                    end else begin
                        fs_ena_nxt = ~fs_ena;
                        state_nxt  = REQ;
                        pf_clr     = 1'b1;
                        pend_nxt   = 1'b0;
                        if (!redir && pf_busy) begin
                            // The speculative read already targets pc+1; it becomes the demand read.
                            pc_nxt = iwb_adr;
                        end else if (pf_busy && !iwb_ack) begin
                            // Bus still busy with a useless read: finish it in REQ, then relaunch.
                            pend_nxt = 1'b1;
                            tgt_nxt  = target;
                        end else begin
                            launch_adr  = redir ? target : pc + word_t'(1);
                            pc_nxt      = launch_adr;
                            iwb_adr_nxt = launch_adr;
                            iwb_stb_nxt = 1'b1;
                        end
                    end
                end else begin
                    if (pc_ld) begin
                        pend_nxt = 1'b1;
                        tgt_nxt  = pc_dti;
                        pf_kill  = 1'b1;
                    end
                    if (pf_busy && iwb_ack) iwb_stb_nxt = 1'b0;
                end
`else
                if (ena) begin
                    launch_adr  = redir ? target : pc + word_t'(1);
                    pc_nxt      = launch_adr;
                    iwb_adr_nxt = launch_adr;
                    iwb_stb_nxt = 1'b1;
                    fs_ena_nxt  = ~fs_ena;
                    pend_nxt    = 1'b0;
                    state_nxt   = REQ;
                end else if (pc_ld) begin
                    pend_nxt = 1'b1;
                    tgt_nxt  = pc_dti;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers; reset drops the strobe immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            tgt     <= '0;
            pend    <= 1'b0;
            fs_dti  <= '0;
            fs_adr  <= '0;
            fs_ena  <= 1'b0;
            fs_ack  <= 1'b0;
            iwb_adr <= '0;
            iwb_stb <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            tgt     <= tgt_nxt;
            pend    <= pend_nxt;
            fs_dti  <= fs_dti_nxt;
            fs_adr  <= fs_adr_nxt;
            fs_ena  <= fs_ena_nxt;
            fs_ack  <= fs_ack_nxt;
            iwb_adr <= iwb_adr_nxt;
            iwb_stb <= iwb_stb_nxt;
        end
    end

endmodule : dcpu16_fetch

// File: tb/tb_dcpu16_fetch.sv
// tb_dcpu16_fetch: directed self-checking bench for dcpu16_fetch (default build).
// A small wait-state memory model answers the instruction bus; expected
// words come from the same address-to-data function the memory uses.
module tb_dcpu16_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena;
    logic        pc_ld = 1'b0;
    logic [15:0] pc_dti = 16'h0000;
    logic [15:0] fs_dti, fs_adr, iwb_adr, iwb_dat;
    logic        fs_ena, fs_ack, iwb_stb, iwb_ack;

    logic        auto_ena = 1'b1;
    logic        man_ena  = 1'b0;
    int          wait_n   = 0;
    int          cnt      = 0;
    int          checks   = 0;
    int          failures = 0;

    dcpu16_fetch dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .pc_ld   (pc_ld),
        .pc_dti  (pc_dti),
        .fs_dti  (fs_dti),
        .fs_adr  (fs_adr),
        .fs_ena  (fs_ena),
        .fs_ack  (fs_ack),
        .iwb_adr (iwb_adr),
        .iwb_stb (iwb_stb),
        .iwb_dat (iwb_dat),
        .iwb_ack (iwb_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0000) return 16'h7C01;
        return {a[7:0], ~a[15:8]} ^ 16'h1357;
    endfunction

    // Memory slave: acks after wait_n extra strobe cycles.
    always @(posedge clk) begin
        if (iwb_stb && !iwb_ack) cnt <= cnt + 1;
        else                     cnt <= 0;
    end
    assign iwb_ack = iwb_stb && (cnt == wait_n);
    assign iwb_dat = iwb_ack ? mem_word(iwb_adr) : 16'hDEAD;
    assign ena     = auto_ena ? (fs_ena == fs_ack) : man_ena;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Wait for the next fs_ack toggle and check the presented word and its latency.
    task automatic wait_present(input logic [15:0] exp_adr, input int exp_lat, input string tag);
        logic prev;
        int   n;
        int   diff;
        bit   seen;
        prev = fs_ack;
        n    = 0;
        diff = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (fs_ack != prev)        seen = 1'b1;
            else if (fs_ena != fs_ack) diff++;
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        check({tag, "_adr"},  32'(fs_adr), 32'(exp_adr));
        check({tag, "_dti"},  32'(fs_dti), 32'(mem_word(exp_adr)));
        check({tag, "_lat"},  32'(n), 32'(exp_lat));
        check({tag, "_stall"}, 32'(diff), 32'(exp_lat - 1));
        check({tag, "_eq"},   32'(fs_ena ^ fs_ack), 32'd0);
    endtask

    initial begin
        logic prev_ack;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_stb",    32'(iwb_stb), 32'd0);
        check("rst_iwbadr", 32'(iwb_adr), 32'd0);
        check("rst_fsena",  32'(fs_ena),  32'd0);
        check("rst_fsack",  32'(fs_ack),  32'd0);
        check("rst_fsdti",  32'(fs_dti),  32'd0);
        check("rst_fsadr",  32'(fs_adr),  32'd0);

        // First fetch at 0-wait.
        rst = 1'b1;
        @(negedge clk);
        check("c1_stb",    32'(iwb_stb), 32'd1);
        check("c1_iwbadr", 32'(iwb_adr), 32'd0);
        check("c1_fsena",  32'(fs_ena),  32'd1);
        check("c1_fsack",  32'(fs_ack),  32'd0);
        @(negedge clk);
        check("c2_fsack",  32'(fs_ack),  32'd1);
        check("c2_fsdti",  32'(fs_dti),  32'h7C01);
        check("c2_fsadr",  32'(fs_adr),  32'd0);
        check("c2_stb",    32'(iwb_stb), 32'd0);
        wait_present(16'h0001, 2, "w1");

        // Sequential words with a 3-wait memory.
        wait_n = 3;
        wait_present(16'h0002, 5, "w2");
        wait_present(16'h0003, 5, "w3");
        wait_present(16'h0004, 5, "w4");

        // Redirect during the in-flight read of address 5.
        prev_ack = fs_ack;
        @(negedge clk);
        check("inf_launch", 32'(iwb_adr), 32'h0005);
        pc_ld  = 1'b1;
        pc_dti = 16'h0100;
        @(negedge clk);
        pc_ld = 1'b0;
        repeat (3) @(negedge clk);
        check("inf_reladr", 32'(iwb_adr), 32'h0100);
        check("inf_relstb", 32'(iwb_stb), 32'd1);
        check("inf_noack",  32'(fs_ack),  32'(prev_ack));
        check("inf_stall",  32'(fs_ena ^ fs_ack), 32'd1);
        wait_present(16'h0100, 4, "inf_w");

        // Redirect while holding a word, with ena.
        pc_ld  = 1'b1;
        pc_dti = 16'h0040;
        @(negedge clk);
        pc_ld = 1'b0;
        check("hld_adr", 32'(iwb_adr), 32'h0040);
        wait_present(16'h0040, 4, "hld_w");

        // Wrap from 16'hFFFF to 16'h0000.
        wait_n = 0;
        pc_ld  = 1'b1;
        pc_dti = 16'hFFFF;
        @(negedge clk);
        pc_ld = 1'b0;
        check("wrp_ffff", 32'(iwb_adr), 32'hFFFF);
        wait_present(16'hFFFF, 1, "wrp_w0");
        @(negedge clk);
        check("wrp_adr0", 32'(iwb_adr), 32'h0000);
        check("wrp_stb",  32'(iwb_stb), 32'd1);
        wait_present(16'h0000, 1, "wrp_w1");

        // ena low holds everything.
        auto_ena = 1'b0;
        man_ena  = 1'b0;
        repeat (4) @(negedge clk);
        check("hold_adr", 32'(fs_adr),  32'h0000);
        check("hold_stb", 32'(iwb_stb), 32'd0);
        check("hold_eq",  32'(fs_ena ^ fs_ack), 32'd0);
        man_ena = 1'b1;
        @(negedge clk);
        man_ena = 1'b0;
        check("hold_next", 32'(iwb_adr), 32'h0001);
        wait_present(16'h0001, 1, "hold_w");

        // Asynchronous reset in the middle of a transfer.
        wait_n  = 3;
        man_ena = 1'b1;
        @(negedge clk);
        man_ena = 1'b0;
        check("art_stb1", 32'(iwb_stb), 32'd1);
        check("art_adr",  32'(iwb_adr), 32'h0002);
        #2 rst = 1'b0;
        #1;
        check("art_stb0",  32'(iwb_stb), 32'd0);
        check("art_fsena", 32'(fs_ena),  32'd0);
        check("art_fsadr", 32'(fs_adr),  32'd0);

        // Redirect held across reset release replaces the first launch address.
        wait_n   = 0;
        auto_ena = 1'b1;
        pc_ld    = 1'b1;
        pc_dti   = 16'h0200;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        pc_ld = 1'b0;
        check("idl_adr",   32'(iwb_adr), 32'h0200);
        check("idl_fsena", 32'(fs_ena),  32'd1);
        wait_present(16'h0200, 1, "idl_w0");
        wait_present(16'h0201, 2, "idl_w1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule : tb_dcpu16_fetch
